sva_fell_checker: RTL and testbench

SVA_FELL_CHECKER -- requirements
Module: sva_fell_checker

---
 rtl/sva_chk_pkg.sv | 46 ++++
 rtl/sva_edge_det.sv | 40 ++++
 rtl/sva_fell_checker.sv | 221 ++++++++++++++++++++++
 tb/tb_sva_fell_checker.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sva_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sva_chk_pkg
// Description : Shared types and default widths for the fell-edge checker
//               (sva_fell_checker / sva_edge_det).
//               - chk_state_e  : checker FSM state encoding
//               - chk_result_e : per-sample outcome encoding
//               - classify()   : outcome of a |-> fell(b) for one sample
// Config      : none here; the top honours CHK_STAMP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package sva_chk_pkg;

    localparam int unsigned c_def_cnt_w   = 16;
    localparam int unsigned c_def_stamp_w = 32;

    // State encoding is visible on state_o, so the values are fixed.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_HALTED = 2'd2
    } chk_state_e;

    typedef enum logic [1:0] {
        RES_NONE = 2'd0,
        RES_VAC  = 2'd1,
        RES_PASS = 2'd2,
        RES_FAIL = 2'd3
    } chk_result_e;

    // Exactly one outcome per evaluated sample: a low antecedent is a
    // vacuous pass, otherwise the falling edge decides pass or fail.
    function automatic chk_result_e classify(input logic ant, input logic fell);
        chk_result_e res;
        if (!ant) begin
            res = RES_VAC;
        end else if (fell) begin
            res = RES_PASS;
        end else begin
            res = RES_FAIL;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sva_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : sva_edge_det
// Description : One-signal edge detector. Keeps the previous posedge sample
//               of sig_i and reports rose/fell/stable against it.
// Ports       : clk       in  sampling clock (posedge)
//               rst_n     in  asynchronous active-low reset (sample -> 0)
//               sig_i     in  monitored signal
//               rose_o    out prev=0, now=1
//               fell_o    out prev=1, now=0
//               stable_o  out prev==now
// Revision    : 1.0 - initial release
// ============================================================================
module sva_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rose_o,
    output logic fell_o,
    output logic stable_o
);

    logic sig_q;

    // The sample register runs every posedge with no enable, so the
    // "previous" value is always the true previous sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rose_o   = ~sig_q &  sig_i;
    assign fell_o   =  sig_q & ~sig_i;
    assign stable_o = ~(sig_q ^ sig_i);

endmodule
`default_nettype wire

// File: rtl/sva_fell_checker.sv
`default_nettype none
// ============================================================================
// Module      : sva_fell_checker
// Description : Hardware checker for the property a |-> fell(b), evaluated
//               once per enabled posedge. Each evaluated sample yields one
//               outcome (vacuous / pass / fail) that is registered into a
//               result stage and reported one clock later as a pulse plus a
//               saturating counter update.
// Parameters  : CNT_W        width of each outcome counter
//               HALT_ON_FAIL 1 = stop checking after the first failure
//               STAMP_W      width of the cycle stamp
// Config      : `define CHK_STAMP_EN adds the enabled-cycle stamp counter
//               and the first_fail_cyc output.
// Ports       : clk, rst_n        clock / async active-low reset
//               en, clr           check enable / synchronous clear
//               a, b              antecedent / consequent
//               pass_pulse, vac_pulse, fail_pulse   one-cycle outcomes
//               pass_cnt, vac_cnt, fail_cnt         saturating counts
//               sticky_fail       set on first failure, held until clr
//               state_o           IDLE=0, CHECK=1, HALTED=2
//               first_fail_cyc    stamp of first failure (CHK_STAMP_EN)
// Revision    : 1.0 - initial release
// ============================================================================
module sva_fell_checker
    import sva_chk_pkg::*;
#(
    parameter int unsigned CNT_W        = c_def_cnt_w,
    parameter bit          HALT_ON_FAIL = 1'b0,
    parameter int unsigned STAMP_W      = c_def_stamp_w
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr,
    input  logic               a,
    input  logic               b,
    output logic               pass_pulse,
    output logic               vac_pulse,
    output logic               fail_pulse,
    output logic [CNT_W-1:0]   pass_cnt,
    output logic [CNT_W-1:0]   vac_cnt,
    output logic [CNT_W-1:0]   fail_cnt,
    output logic               sticky_fail,
    output logic [1:0]         state_o
`ifdef CHK_STAMP_EN
    ,
    output logic [STAMP_W-1:0] first_fail_cyc
`endif
);

    chk_state_e        state_q, state_d;
    chk_result_e       res_q, res_d;

    logic              pass_pulse_q, vac_pulse_q, fail_pulse_q;
    logic [CNT_W-1:0]  pass_cnt_q, vac_cnt_q, fail_cnt_q;
    logic              sticky_fail_q;

    logic              w_b_rose, w_b_fell, w_b_stable;
    logic              w_eval;
    logic              w_unused_edges;

    // ------------------------------------------------------------------
    // Previous-sample tracking for b
    // ------------------------------------------------------------------
    sva_edge_det u_b_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .sig_i    (b),
        .rose_o   (w_b_rose),
        .fell_o   (w_b_fell),
        .stable_o (w_b_stable)
    );

    assign w_unused_edges = w_b_rose ^ w_b_stable;

    // ------------------------------------------------------------------
    // Sample evaluation. IDLE with en high is the edge into CHECK, and
    // that sample counts. A coinciding clr drops the sample outright.
    // ------------------------------------------------------------------
    assign w_eval = en && !clr && ((state_q == ST_IDLE) || (state_q == ST_CHECK));

    always_comb begin
        res_d = RES_NONE;
        if (w_eval) begin
            res_d = classify(a, w_b_fell);
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. The halt decision uses the outcome of the sample
    // being taken now, so no further sample is evaluated after a fail.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (en) begin
                    if (HALT_ON_FAIL && (res_d == RES_FAIL)) begin
                        state_d = ST_HALTED;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (HALT_ON_FAIL && (res_d == RES_FAIL)) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (clr) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, result stage and reporting. res_q holds the outcome of the
    // previous posedge's sample; pulses and counters are derived from it,
    // giving one clock of latency. The outcome already in res_q when the
    // FSM leaves CHECK is still reported: it belongs to a sample taken
    // while checking was active.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            res_q         <= RES_NONE;
            pass_pulse_q  <= 1'b0;
            vac_pulse_q   <= 1'b0;
            fail_pulse_q  <= 1'b0;
            pass_cnt_q    <= '0;
            vac_cnt_q     <= '0;
            fail_cnt_q    <= '0;
            sticky_fail_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (clr) begin
                res_q         <= RES_NONE;
                pass_pulse_q  <= 1'b0;
                vac_pulse_q   <= 1'b0;
                fail_pulse_q  <= 1'b0;
                pass_cnt_q    <= '0;
                vac_cnt_q     <= '0;
                fail_cnt_q    <= '0;
                sticky_fail_q <= 1'b0;
            end else begin
                res_q        <= res_d;
                pass_pulse_q <= (res_q == RES_PASS);
                vac_pulse_q  <= (res_q == RES_VAC);
                fail_pulse_q <= (res_q == RES_FAIL);

                // Counters stop at all-ones instead of wrapping.
                if ((res_q == RES_PASS) && (pass_cnt_q != '1)) begin
                    pass_cnt_q <= pass_cnt_q + CNT_W'(1);
                end
                if ((res_q == RES_VAC) && (vac_cnt_q != '1)) begin
                    vac_cnt_q <= vac_cnt_q + CNT_W'(1);
                end
                if ((res_q == RES_FAIL) && (fail_cnt_q != '1)) begin
                    fail_cnt_q <= fail_cnt_q + CNT_W'(1);
                end

                // Rises on the same edge as the first fail_pulse.
                if (res_q == RES_FAIL) begin
                    sticky_fail_q <= 1'b1;
                end
            end
        end
    end

    assign pass_pulse  = pass_pulse_q;
    assign vac_pulse   = vac_pulse_q;
    assign fail_pulse  = fail_pulse_q;
    assign pass_cnt    = pass_cnt_q;
    assign vac_cnt     = vac_cnt_q;
    assign fail_cnt    = fail_cnt_q;
    assign sticky_fail = sticky_fail_q;
    assign state_o     = state_q;

`ifdef CHK_STAMP_EN
    // ------------------------------------------------------------------
    // Enabled-cycle stamp. stamp_q is the index the next evaluated sample
    // will carry (first sample after reset/clr is 0). The index travels
    // alongside res_q so the capture lines up with the reported failure.
    // ------------------------------------------------------------------
    logic [STAMP_W-1:0] stamp_q;
    logic [STAMP_W-1:0] res_stamp_q;
    logic [STAMP_W-1:0] first_fail_cyc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stamp_q          <= '0;
            res_stamp_q      <= '0;
            first_fail_cyc_q <= '0;
        end else if (clr) begin
            stamp_q          <= '0;
            res_stamp_q      <= '0;
            first_fail_cyc_q <= '0;
        end else begin
            if (w_eval) begin
                stamp_q     <= stamp_q + STAMP_W'(1);
                res_stamp_q <= stamp_q;
            end
            if ((res_q == RES_FAIL) && !sticky_fail_q) begin
                first_fail_cyc_q <= res_stamp_q;
            end
        end
    end

    assign first_fail_cyc = first_fail_cyc_q;
`else
    // Without the stamp feature STAMP_W sizes nothing.
    localparam int unsigned c_unused_stamp_w = STAMP_W;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sva_fell_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_sva_fell_checker
// Description : Directed bench for sva_fell_checker. Three instances share
//               the stimulus: default build (d0), HALT_ON_FAIL=1 (dh) and
//               CNT_W=4 (ds). Expected outcomes of d0 are queued as each
//               sample is driven and compared when the pulse is due.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sva_fell_checker;
    import sva_chk_pkg::*;

    logic clk, rst_n, en, clr, a, b;

    logic        d0_pass, d0_vac, d0_fail, d0_sticky;
    logic [15:0] d0_pass_cnt, d0_vac_cnt, d0_fail_cnt;
    logic [1:0]  d0_state;
    logic        dh_pass, dh_vac, dh_fail, dh_sticky;
    logic [15:0] dh_pass_cnt, dh_vac_cnt, dh_fail_cnt;
    logic [1:0]  dh_state;
    logic        ds_pass, ds_vac, ds_fail, ds_sticky;
    logic [3:0]  ds_pass_cnt, ds_vac_cnt, ds_fail_cnt;
    logic [1:0]  ds_state;
`ifdef CHK_STAMP_EN
    logic [31:0] d0_ffc, dh_ffc, ds_ffc;
`endif

    sva_fell_checker u_d0 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b),
        .pass_pulse(d0_pass), .vac_pulse(d0_vac), .fail_pulse(d0_fail),
        .pass_cnt(d0_pass_cnt), .vac_cnt(d0_vac_cnt), .fail_cnt(d0_fail_cnt),
        .sticky_fail(d0_sticky),
`ifdef CHK_STAMP_EN
        .first_fail_cyc(d0_ffc),
`endif
        .state_o(d0_state)
    );

    sva_fell_checker #(.HALT_ON_FAIL(1'b1)) u_dh (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b),
        .pass_pulse(dh_pass), .vac_pulse(dh_vac), .fail_pulse(dh_fail),
        .pass_cnt(dh_pass_cnt), .vac_cnt(dh_vac_cnt), .fail_cnt(dh_fail_cnt),
        .sticky_fail(dh_sticky),
`ifdef CHK_STAMP_EN
        .first_fail_cyc(dh_ffc),
`endif
        .state_o(dh_state)
    );

    sva_fell_checker #(.CNT_W(4)) u_ds (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b),
        .pass_pulse(ds_pass), .vac_pulse(ds_vac), .fail_pulse(ds_fail),
        .pass_cnt(ds_pass_cnt), .vac_cnt(ds_vac_cnt), .fail_cnt(ds_fail_cnt),
        .sticky_fail(ds_sticky),
`ifdef CHK_STAMP_EN
        .first_fail_cyc(ds_ffc),
`endif
        .state_o(ds_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          id;
        chk_result_e res;
    } sb_t;

    sb_t sb[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  cyc   = 0;
    int  sid   = 0;

    function automatic logic [2:0] enc(input chk_result_e r);
        logic [2:0] v;
        case (r)
            RES_PASS: v = 3'b100;
            RES_VAC:  v = 3'b010;
            RES_FAIL: v = 3'b001;
            default:  v = 3'b000;
        endcase
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one posedge, then compare every due scoreboard entry.
    task automatic tick();
        sb_t e;
        @(posedge clk);
        #1;
        cyc++;
        while (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk($sformatf("pulse_s%0d", e.id), {61'd0, d0_pass, d0_vac, d0_fail}, {61'd0, enc(e.res)});
        end
    endtask

    // Drive one sample just after an edge; its outcome is due one clock
    // after the posedge that captures it.
    task automatic sample(input logic ien, input logic iclr, input logic ia,
                          input logic ib, input chk_result_e exp);
        sb_t e;
        en = ien; clr = iclr; a = ia; b = ib;
        e.due = cyc + 2;
        e.id  = sid++;
        e.res = exp;
        sb.push_back(e);
        tick();
    endtask

    initial begin
        sb_t e;
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; a = 1'b0; b = 1'b0;
        #2;
        chk("rst_pulses", {61'd0, d0_pass, d0_vac, d0_fail}, 64'd0);
        chk("rst_counts", {16'd0, d0_pass_cnt, d0_vac_cnt, d0_fail_cnt}, 64'd0);
        chk("rst_state", {62'd0, d0_state}, {62'd0, ST_IDLE});
        chk("rst_sticky", {63'd0, d0_sticky}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reference sequence: vac, vac, pass, fail, vac, fail, fail
        sample(1, 0, 0, 0, RES_VAC);
        sample(1, 0, 0, 1, RES_VAC);
        sample(1, 0, 1, 0, RES_PASS);
        sample(1, 0, 1, 1, RES_FAIL);
        chk("halt_state", {62'd0, dh_state}, {62'd0, ST_HALTED});
        sample(1, 0, 0, 0, RES_VAC);
        chk("halt_last_fail_pulse", {63'd0, dh_fail}, 64'd1);
        chk("halt_sticky", {63'd0, dh_sticky}, 64'd1);
        sample(1, 0, 1, 1, RES_FAIL);
        chk("halt_no_pulse", {61'd0, dh_pass, dh_vac, dh_fail}, 64'd0);
        sample(1, 0, 1, 1, RES_FAIL);
        sample(0, 0, 0, 0, RES_NONE);
        tick();
        chk("seq_pass_cnt", {48'd0, d0_pass_cnt}, 64'd1);
        chk("seq_vac_cnt", {48'd0, d0_vac_cnt}, 64'd3);
        chk("seq_fail_cnt", {48'd0, d0_fail_cnt}, 64'd3);
        chk("seq_sticky", {63'd0, d0_sticky}, 64'd1);
        chk("seq_state_idle", {62'd0, d0_state}, {62'd0, ST_IDLE});
        chk("halt_counts", {16'd0, dh_pass_cnt, dh_vac_cnt, dh_fail_cnt},
            {16'd0, 16'd1, 16'd2, 16'd1});
        chk("halt_hold", {62'd0, dh_state}, {62'd0, ST_HALTED});
`ifdef CHK_STAMP_EN
        chk("seq_first_fail_cyc", {32'd0, d0_ffc}, 64'd3);
`endif

        // Clear: counts and flags drop, HALTED returns to IDLE
        sample(0, 1, 0, 0, RES_NONE);
        chk("clr_d0_counts", {16'd0, d0_pass_cnt, d0_vac_cnt, d0_fail_cnt}, 64'd0);
        chk("clr_d0_sticky", {63'd0, d0_sticky}, 64'd0);
        chk("clr_halt_state", {62'd0, dh_state}, {62'd0, ST_IDLE});
        chk("clr_halt_counts", {16'd0, dh_pass_cnt, dh_vac_cnt, dh_fail_cnt}, 64'd0);

        // clr coinciding with a would-be failing sample
        sample(1, 1, 1, 1, RES_NONE);
        chk("coll_state", {62'd0, d0_state}, {62'd0, ST_CHECK});
        sample(0, 0, 0, 0, RES_NONE);
        tick();
        chk("coll_fail_cnt", {48'd0, d0_fail_cnt}, 64'd0);
        chk("coll_sticky", {63'd0, d0_sticky}, 64'd0);

        // Enable toggle around a b fall taken while disabled
        sample(1, 0, 0, 1, RES_VAC);
        sample(0, 0, 1, 0, RES_NONE);
        sample(1, 0, 1, 0, RES_FAIL);
        sample(0, 0, 0, 0, RES_NONE);
        tick();
        chk("en_counts", {16'd0, d0_pass_cnt, d0_vac_cnt, d0_fail_cnt},
            {16'd0, 16'd0, 16'd1, 16'd1});
        chk("en_sticky", {63'd0, d0_sticky}, 64'd1);
`ifdef CHK_STAMP_EN
        chk("en_first_fail_cyc", {32'd0, d0_ffc}, 64'd1);
`endif

        // Saturation: 20 failing samples
        sample(0, 1, 0, 0, RES_NONE);
        for (int i = 0; i < 20; i++) begin
            sample(1, 0, 1, 1, RES_FAIL);
        end
        sample(0, 0, 0, 1, RES_NONE);
        tick();
        chk("sat_fail_cnt_w4", {60'd0, ds_fail_cnt}, 64'd15);
        chk("sat_fail_cnt_w16", {48'd0, d0_fail_cnt}, 64'd20);
        chk("sat_halt_fail_cnt", {48'd0, dh_fail_cnt}, 64'd1);
        chk("sat_halt_state", {62'd0, dh_state}, {62'd0, ST_HALTED});
        chk("sat_sticky_w4", {63'd0, ds_sticky}, 64'd1);

        // Asynchronous reset mid-cycle, checked before any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_d0_all", {10'd0, d0_pass, d0_vac, d0_fail, d0_pass_cnt, d0_vac_cnt,
                            d0_fail_cnt, d0_sticky, d0_state}, 64'd0);
        chk("arst_ds_fail_cnt", {60'd0, ds_fail_cnt}, 64'd0);
        chk("arst_dh_state", {62'd0, dh_state}, {62'd0, ST_IDLE});

        // b was 1 before reset; the first sample must still see b_prev=0
        @(negedge clk);
        rst_n = 1'b1; en = 1'b1; clr = 1'b0; a = 1'b1; b = 1'b0;
        e.due = cyc + 2;
        e.id  = sid++;
        e.res = RES_FAIL;
        sb.push_back(e);
        tick();
        sample(0, 0, 0, 0, RES_NONE);
        tick();
        chk("post_rst_fail_cnt", {48'd0, d0_fail_cnt}, 64'd1);
        chk("post_rst_pass_cnt", {48'd0, d0_pass_cnt}, 64'd0);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
